// File: rtl/grom_loader_pkg.sv
// grom_loader_pkg: shared state encoding, GROM geometry and wishbone address layout
package grom_loader_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WRITE,
    S_VERIFY,
    S_ADVANCE,
    S_FINISH,
    S_ERROR
  } state_t;
  localparam int GROM_PAGE_BYTES = 2048;
  localparam int GROM_PAGES      = 3;
  localparam int GROM_BYTES      = GROM_PAGES * GROM_PAGE_BYTES;
  localparam int ADR_GROM_LSB    = 13;
  localparam int ADR_GROM_W      = 3;
  localparam int ADR_PAGE_LSB    = 11;
  localparam int ADR_PAGE_W      = 2;
  localparam int ADR_OFF_LSB     = 0;
  localparam int ADR_OFF_W       = 11;
  // Wishbone address: grom in the top 3 bits, then page, then 11-bit offset.
  function automatic logic [15:0] grom_adr(input logic [2:0] g, input logic [1:0] p, input logic [10:0] o);
    return {g, p, o};
  endfunction
endpackage

// File: rtl/grom_addr_counter.sv
// grom_addr_counter: grom/page/offset incrementer that skips page 3 and flags overrun
module grom_addr_counter
  import grom_loader_pkg::*;
#(
  parameter int NUM_GROMS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic [2:0]  i_grom,
  input  logic        i_inc,
  output logic [15:0] o_adr,
  output logic [15:0] o_nxt_adr,
  output logic        o_nxt_ovf
);
  logic [2:0]  r_grom;
  logic [1:0]  r_page;
  logic [10:0] r_off;
  logic        w_off_wrap;
  logic        w_page_wrap;
  logic [3:0]  w_nxt_grom;
  logic [1:0]  w_nxt_page;
  logic [10:0] w_nxt_off;
  // Next address: offset wraps into the next page, page 2 wraps into the next GROM.
  always_comb begin
    w_off_wrap  = &r_off;
    w_page_wrap = w_off_wrap && (r_page == 2'(GROM_PAGES - 1));
    w_nxt_off   = r_off + 11'd1;
    w_nxt_page  = w_page_wrap ? 2'd0 : w_off_wrap ? r_page + 2'd1 : r_page;
    w_nxt_grom  = {1'b0, r_grom} + {3'd0, w_page_wrap};
  end
  assign o_adr     = grom_adr(r_grom, r_page, r_off);
  assign o_nxt_adr = grom_adr(w_nxt_grom[2:0], w_nxt_page, w_nxt_off);
  assign o_nxt_ovf = int'(w_nxt_grom) >= NUM_GROMS;
  // Position register: load restarts at page 0 offset 0, inc steps one byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grom <= '0;
      r_page <= '0;
      r_off  <= '0;
    end else if (i_load) begin
      r_grom <= i_grom;
      r_page <= '0;
      r_off  <= '0;
    end else if (i_inc) begin
      r_grom <= w_nxt_grom[2:0];
      r_page <= w_nxt_page;
      r_off  <= w_nxt_off;
    end
  end
endmodule

// File: rtl/grom_loader.sv
// grom_loader: wishbone master filling the GROM store from a byte stream, with optional verify
module grom_loader
  import grom_loader_pkg::*;
#(
  parameter int NUM_GROMS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  start_grom,
  input  logic [14:0] byte_count,
  input  logic        verify,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] err_adr,
  output logic [15:0] wb_adr_o,
  output logic [7:0]  wb_dat_o,
  input  logic [7:0]  wb_dat_i,
  output logic        wb_we_o,
  output logic        wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i
);
  state_t      r_state;
  state_t      w_next;
  logic [14:0] r_remaining;
  logic        r_verify;
  logic        r_error;
  logic [15:0] r_err_adr;
  logic [7:0]  r_dat;
  logic        w_accept;
  logic        w_bad_start;
  logic [15:0] w_nxt_adr;
  logic        w_nxt_ovf;
  logic [15:0] w_err_adr;
  assign w_accept    = start && (r_state == S_IDLE);
  assign w_bad_start = int'(start_grom) >= NUM_GROMS;
  grom_addr_counter #(.NUM_GROMS(NUM_GROMS)) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_accept),
    .i_grom    (start_grom),
    .i_inc     (r_state == S_ADVANCE),
    .o_adr     (wb_adr_o),
    .o_nxt_adr (w_nxt_adr),
    .o_nxt_ovf (w_nxt_ovf)
  );
  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end
  // Next state, the address to report if we fail, and the state-decoded outputs.
  always_comb begin
    w_next    = r_state;
    w_err_adr = '0;
    s_ready   = r_state == S_FETCH;
    busy      = r_state inside {S_FETCH, S_WRITE, S_VERIFY, S_ADVANCE};
    done      = r_state == S_FINISH;
    wb_cyc_o  = r_state inside {S_WRITE, S_VERIFY};
    wb_stb_o  = wb_cyc_o;
    wb_sel_o  = wb_cyc_o;
    wb_we_o   = r_state == S_WRITE;
    case (r_state)
      S_IDLE: begin
        w_err_adr = {start_grom, 13'h0};
        if (start) w_next = (byte_count == '0) ? S_FINISH : w_bad_start ? S_ERROR : S_FETCH;
      end
      S_FETCH:   if (s_valid) w_next = S_WRITE;
      S_WRITE:   if (wb_ack_i) w_next = r_verify ? S_VERIFY : S_ADVANCE;
      S_VERIFY: begin
        w_err_adr = wb_adr_o;
        if (wb_ack_i) w_next = (wb_dat_i == r_dat) ? S_ADVANCE : S_ERROR;
      end
      S_ADVANCE: begin
        w_err_adr = w_nxt_adr;
        w_next    = (r_remaining == 15'd1) ? S_FINISH : w_nxt_ovf ? S_ERROR : S_FETCH;
      end
      default:   w_next = S_IDLE;
    endcase
  end
  // Transfer bookkeeping: latched job, stream byte, sticky error and its address.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_remaining <= '0;
      r_verify    <= 1'b0;
      r_error     <= 1'b0;
      r_err_adr   <= '0;
      r_dat       <= '0;
    end else begin
      if (w_accept) begin
        r_remaining <= byte_count;
        r_verify    <= verify;
      end
      if (r_state == S_ADVANCE) r_remaining <= r_remaining - 15'd1;
      if (r_state == S_FETCH && s_valid) r_dat <= s_data;
      r_error   <= (w_next == S_ERROR) ? 1'b1 : w_accept ? 1'b0 : r_error;
      r_err_adr <= (w_next == S_ERROR) ? w_err_adr : r_err_adr;
    end
  end
  assign error    = r_error;
  assign err_adr  = r_err_adr;
  assign wb_dat_o = r_dat;
endmodule
